// File: rtl/collatz_sweep_sched.sv
// Collatz sweep scheduler: drives one Collatz core over seeds BASE..BASE+COUNT-1 and tracks the longest orbit.
// Optional per-seed watchdog enabled by defining COLLATZ_SWEEP_WATCHDOG_EN.
module collatz_sweep_sched #(
  parameter int BITS      = 32,
  parameter int OLEN_BITS = 16,
  parameter int CNT_BITS  = 16,
  parameter int EVT_BITS  = 8,
  parameter int MAX_STEPS = 4096
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 abort,
  input  logic [BITS-1:0]      base_seed,
  input  logic [CNT_BITS-1:0]  count,
  output logic                 core_start,
  output logic [BITS-1:0]      core_seed,
  output logic                 core_abort,
  input  logic                 core_done,
  input  logic [OLEN_BITS-1:0] core_len,
  input  logic [BITS-1:0]      core_record,
  input  logic                 core_ovf,
  output logic                 busy,
  output logic                 done,
  output logic [BITS-1:0]      best_seed,
  output logic [OLEN_BITS-1:0] best_len,
  output logic [BITS-1:0]      best_record,
  output logic [EVT_BITS-1:0]  ovf_cnt,
  output logic [EVT_BITS-1:0]  tmo_cnt
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RUN, S_NEXT, S_DONE} state_t;

  localparam logic [EVT_BITS-1:0] EVT_MAX = {EVT_BITS{1'b1}};

  state_t                state_r;
  logic [BITS-1:0]       seed_r;
  logic [CNT_BITS-1:0]   rem_r;
  logic [OLEN_BITS-1:0]  res_len_r;
  logic [BITS-1:0]       res_record_r;
  logic                  res_ovf_r;
  logic                  res_valid_r;
  logic                  have_best_r;
  logic [BITS-1:0]       seed_nxt_s;

`ifdef COLLATZ_SWEEP_WATCHDOG_EN
  localparam int WD_BITS = $clog2(MAX_STEPS + 1);
  logic [WD_BITS-1:0]    wd_cnt_r;
  logic                  res_tmo_r;
`else
  assign tmo_cnt = '0;
`endif

  assign seed_nxt_s = seed_r + BITS'(1);

  // Sweep FSM with all outputs registered; abort overrides every non-idle state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= S_IDLE;
      seed_r       <= '0;
      rem_r        <= '0;
      res_len_r    <= '0;
      res_record_r <= '0;
      res_ovf_r    <= 1'b0;
      res_valid_r  <= 1'b0;
      have_best_r  <= 1'b0;
      core_start   <= 1'b0;
      core_seed    <= '0;
      core_abort   <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      best_seed    <= '0;
      best_len     <= '0;
      best_record  <= '0;
      ovf_cnt      <= '0;
`ifdef COLLATZ_SWEEP_WATCHDOG_EN
      tmo_cnt      <= '0;
      wd_cnt_r     <= '0;
      res_tmo_r    <= 1'b0;
`endif
    end else begin
      core_start <= 1'b0;
      core_abort <= 1'b0;
      done       <= 1'b0;
      if (abort && (state_r != S_IDLE)) begin
        state_r    <= S_IDLE;
        busy       <= 1'b0;
        core_abort <= (state_r == S_RUN);
      end else begin
        case (state_r)
          S_IDLE: begin
            if (start) begin
              seed_r      <= base_seed;
              rem_r       <= count;
              best_seed   <= '0;
              best_len    <= '0;
              best_record <= '0;
              have_best_r <= 1'b0;
              ovf_cnt     <= '0;
`ifdef COLLATZ_SWEEP_WATCHDOG_EN
              tmo_cnt     <= '0;
`endif
              busy        <= 1'b1;
              if (count == CNT_BITS'(0)) begin
                state_r <= S_DONE;
                done    <= 1'b1;
              end else begin
                state_r    <= S_LOAD;
                core_start <= (base_seed != BITS'(0));
                core_seed  <= base_seed;
              end
            end
          end
          S_LOAD: begin
            // Stale results must not leak into the fold of a skipped seed.
            res_valid_r <= 1'b0;
`ifdef COLLATZ_SWEEP_WATCHDOG_EN
            res_tmo_r   <= 1'b0;
            wd_cnt_r    <= '0;
`endif
            state_r     <= (seed_r == BITS'(0)) ? S_NEXT : S_RUN;
          end
          S_RUN: begin
            if (core_done) begin
              res_len_r    <= core_len;
              res_record_r <= core_record;
              res_ovf_r    <= core_ovf;
              res_valid_r  <= 1'b1;
              state_r      <= S_NEXT;
            end
`ifdef COLLATZ_SWEEP_WATCHDOG_EN
            else if (wd_cnt_r == WD_BITS'(MAX_STEPS - 1)) begin
              core_abort <= 1'b1;
              res_tmo_r  <= 1'b1;
              state_r    <= S_NEXT;
            end else begin
              wd_cnt_r <= wd_cnt_r + WD_BITS'(1);
            end
`endif
          end
          S_NEXT: begin
            if (res_valid_r) begin
              if (res_ovf_r) begin
                if (ovf_cnt != EVT_MAX) ovf_cnt <= ovf_cnt + EVT_BITS'(1);
              end else if (!have_best_r || (res_len_r > best_len)) begin
                best_seed   <= seed_r;
                best_len    <= res_len_r;
                best_record <= res_record_r;
                have_best_r <= 1'b1;
              end
            end
`ifdef COLLATZ_SWEEP_WATCHDOG_EN
            if (res_tmo_r && (tmo_cnt != EVT_MAX)) tmo_cnt <= tmo_cnt + EVT_BITS'(1);
`endif
            rem_r  <= rem_r - CNT_BITS'(1);
            seed_r <= seed_nxt_s;
            if (rem_r == CNT_BITS'(1)) begin
              state_r <= S_DONE;
              done    <= 1'b1;
            end else begin
              state_r    <= S_LOAD;
              core_start <= (seed_nxt_s != BITS'(0));
              core_seed  <= seed_nxt_s;
            end
          end
          S_DONE: begin
            state_r <= S_IDLE;
            busy    <= 1'b0;
          end
          default: begin
            state_r <= S_IDLE;
            busy    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
